// File: rtl/gpio_pixel_uart_pkg.sv
// gpio_pixel_uart_pkg: shared types and constants for the GPIO pixel UART bridge
package gpio_pixel_uart_pkg;
  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_e;
  typedef logic [23:0] pixel_t;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int BYTES_PER_PIXEL = 3;
endpackage

// File: rtl/gpio_pixel_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte transmitter with valid/ready handshake
module uart_tx_byte
  import gpio_pixel_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       idle
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic last;
  always_comb begin
    last = cnt_q == CW'(CLKS_PER_BIT - 1);
    state_d = state_q;
    cnt_d = (state_q == UART_IDLE || last) ? '0 : cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    // accepting in the last stop cycle chains the next byte without an idle gap
    in_ready = state_q == UART_IDLE || (state_q == UART_STOP && last);
    if (in_valid && in_ready) begin
      state_d = UART_START;
      sh_d = in_data;
    end else if (last) begin
      case (state_q)
        UART_START: begin
          state_d = UART_DATA;
          bit_d = 3'd0;
        end
        UART_DATA: begin
          sh_d = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          state_d = bit_q == 3'd7 ? UART_STOP : UART_DATA;
        end
        UART_STOP: state_d = UART_IDLE;
        default: state_d = state_q;
      endcase
    end
    tx = state_q == UART_START ? 1'b0 : state_q == UART_DATA ? sh_q[0] : IDLE_LEVEL;
    idle = state_q == UART_IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UART_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
    end
  end
endmodule

// File: rtl/gpio_pixel_uart.sv
// gpio_pixel_uart: assembles R/G/B GPIO bytes into pixels, buffers them and
// streams each pixel over an 8N1 UART as three bytes.
module gpio_pixel_uart
  import gpio_pixel_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio,
  input  logic        gpio_en_r,
  input  logic        gpio_en_g,
  input  logic        gpio_en_b,
  input  logic        gpio_en,
  output logic        uart_tx,
  output logic        busy,
  output logic        overflow,
  output logic        chan_err,
  output logic        done,
  output logic [15:0] pixel_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_PIXEL - 1);
  pixel_t mem_q [FIFO_DEPTH];
  pixel_t pix_q, pix_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d, tx_byte;
  logic [2:0] vld_q, vld_d, stb;
  logic [1:0] idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic act_q, act_d, ovf_q, ovf_d, err_q, err_d, dpend_q, dpend_d;
  logic empty, full, push_req, push, pop, tx_ready, tx_idle;
  logic unused_gpio;
  assign unused_gpio = ^gpio[31:8];
  always_comb begin
    stb = {gpio_en_r, gpio_en_g, gpio_en_b};
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    push_req = &vld_q;
    pop = !act_q && !empty && tx_idle;
    push = push_req && (!full || pop);
    // a strobe in the push cycle belongs to the next pixel, not a collision
    vld_d = stb | (vld_q & {3{!push_req}});
    r_d = gpio_en_r ? gpio[7:0] : r_q;
    g_d = gpio_en_g ? gpio[7:0] : g_q;
    b_d = gpio_en_b ? gpio[7:0] : b_q;
    err_d = err_q | ((|(stb & vld_q)) & !push_req);
    ovf_d = ovf_q | (push_req && !push);
    cnt_d = cnt_q + 16'(push);
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    tx_byte = idx_q == 2'd0 ? pix_q[23:16] : idx_q == 2'd1 ? pix_q[15:8] : pix_q[7:0];
    act_d = pop || (act_q && !(tx_ready && idx_q == LAST_IDX));
    idx_d = pop ? 2'd0 : (act_q && tx_ready) ? idx_q + 2'd1 : idx_q;
    pix_d = pop ? mem_q[rd_q[AW-1:0]] : pix_q;
    done = dpend_q && !(|vld_q) && empty && tx_idle && !act_q;
    dpend_d = gpio_en || (dpend_q && !done);
    busy = (|vld_q) || !empty || !tx_idle || act_q;
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {r_q, g_q, b_q};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      vld_q <= '0;
      pix_q <= '0;
      idx_q <= '0;
      act_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      dpend_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      vld_q <= vld_d;
      pix_q <= pix_d;
      idx_q <= idx_d;
      act_q <= act_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      dpend_q <= dpend_d;
    end
  end
  assign overflow = ovf_q;
  assign chan_err = err_q;
  assign pixel_count = cnt_q;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .rst(rst),
    .in_valid(act_q),
    .in_data(tx_byte),
    .in_ready(tx_ready),
    .tx(uart_tx),
    .idle(tx_idle)
  );
endmodule
